logic_unit: RTL and testbench
=============================

# logic_unit

Parametrised, registered multi-operation bitwise logic unit for the CPU datapath. It is the successor to the single-bit combinational gate primitives. It applies one of eight bitwise operations to two WIDTH-bit operands and presents the result, with zero/all-ones flags, one cycle later. Input and output use valid/ready handshakes, and a two-entry output skid buffer sustains one result per cycle under backpressure. It sits between operand fetch and the writeback mux.

## Interface
- WIDTH, 8: operand and result width in bits, at least 1.
- COUNT_W, 16: width of the accepted-transaction counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept; transfer occurs when in_valid && in_ready.
- in_op  input  3  operation select, encoded as below.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts; transfer occurs when out_valid && out_ready.
- out_y  output  WIDTH  result.
- out_zero  output  1  out_y == 0.
- out_ones  output  1  out_y is all ones.
- txn_count  output  COUNT_W  number of accepted inputs, modulo 2^COUNT_W.

## Operation
- Op encoding (bitwise, per bit):
  - 0 AND, 1 OR, 2 NOR, 3 NAND
  - 4 XOR, 5 XNOR
  - 6 NOT A (in_b ignored)
  - 7 PASS B (in_a ignored)
- Result and flags are computed combinationally from the accepted inputs and captured into storage. Flags are computed from the captured result, never recomputed at the output.
- Storage is two entries:
  - main (drives the out_* ports).
  - skid (holds a second result when main is stalled).
- in_ready = !skid_valid. It is a function of registered state only; there is no combinational path from out_ready.
- On each edge, with accept = in_valid && in_ready and pop = out_valid && out_ready:
  - main empty, accept: new result loads into main.
  - main full, pop, skid empty, accept: new result loads into main.
  - main full, pop, skid empty, no accept: main empties.
  - main full, pop, skid full: skid moves to main and skid empties. No accept is possible here because in_ready = 0.
  - main full, no pop, skid empty, accept: new result loads into skid.
  - main full, no pop, skid full: hold everything.
- Results leave in acceptance order. None are dropped or duplicated.
- txn_count increments by 1 on every accept and wraps from 2^COUNT_W-1 to 0.
- in_op values are all defined, so there is no illegal-op state.

## Timing
- Reset (rst_n low, asynchronous) gives:
  - out_valid=0, out_y=0, out_zero=0, out_ones=0
  - skid empty, so in_ready=1
  - txn_count=0
- Reset takes effect immediately, mid-transfer included. In-flight results are discarded.
- The first edge after rst_n rises may accept.
- Latency: input accepted at edge N gives out_valid=1 with the result after edge N, when main was empty or popping at N.
- Throughput: one result per cycle while out_ready=1.
- Backpressure:
  - First stalled cycle: one more input is absorbed into skid, then in_ready falls after that edge.
  - in_ready rises the cycle after skid drains.
- out_y and the flags are stable while out_valid && !out_ready.
- Simultaneous accept and pop on a full main with empty skid is a pass-through replacement: main updates, skid stays empty.

## Structure
- Shared package (cpu_pkg): op encoding constants OP_AND..OP_PASSB and the 3-bit op typedef. No other types.
- Sub-module logic_unit_core: purely combinational (op, a, b) -> (y, zero, ones), parametrised by WIDTH. It is reused by the future ALU.
- Top level: the skid-buffer control, the two storage entries and txn_count.

## Test plan
- Reset: assert rst_n=0 mid-stream with both entries full. Immediately out_valid=0, in_ready=1, txn_count=0.
- Truth sweep: WIDTH=8, out_ready=1, a=8'hF0, b=8'hCC, ops 0..7 back-to-back. Results in order are C0, FC, 03, 3F, 3C, C3, 0F, CC, one per cycle, latency 1. NOR with a=b=8'h00 gives FF with out_ones=1; AND with a=8'h0F, b=8'hF0 gives 00 with out_zero=1.
- Backpressure: out_ready=0, present 3 inputs continuously. Two are accepted and in_ready falls. Then raise out_ready: outputs appear in order, in_ready=1 one cycle after skid drains, and the third input is accepted.
- Pass-through: main full, out_ready=1 and in_valid=1 on the same cycle. Main is replaced, skid stays empty, in_ready stays 1.
- Counter wrap: COUNT_W=4, 17 accepts. txn_count goes 15 then 0, and reads 1 at the end.
- WIDTH=1 instance: all 8 ops over the 4 input combinations. NOR column reads 1,0,0,0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU datapath logic operations.
//   op_t          : 3-bit operation select
//   OP_AND..OP_PASSB : operation encodings (bitwise, applied per bit)
// -----------------------------------------------------------------------------
package cpu_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_AND   = 3'd0;
   localparam op_t OP_OR    = 3'd1;
   localparam op_t OP_NOR   = 3'd2;
   localparam op_t OP_NAND  = 3'd3;
   localparam op_t OP_XOR   = 3'd4;
   localparam op_t OP_XNOR  = 3'd5;
   localparam op_t OP_NOTA  = 3'd6;
   localparam op_t OP_PASSB = 3'd7;

endpackage

// File: rtl/logic_unit_core.sv
// -----------------------------------------------------------------------------
// logic_unit_core
// Purely combinational bitwise operation stage.
//   op_i   : operation select (cpu_pkg encoding)
//   a_i    : operand A, WIDTH bits (ignored for PASS B)
//   b_i    : operand B, WIDTH bits (ignored for NOT A)
//   y_o    : result, WIDTH bits
//   zero_o : y_o is all zeros
//   ones_o : y_o is all ones
// -----------------------------------------------------------------------------
module logic_unit_core
   import cpu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_t              op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o,
   output logic             zero_o,
   output logic             ones_o
);

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_AND:   y_o = a_i & b_i;
         OP_OR:    y_o = a_i | b_i;
         OP_NOR:   y_o = ~(a_i | b_i);
         OP_NAND:  y_o = ~(a_i & b_i);
         OP_XOR:   y_o = a_i ^ b_i;
         OP_XNOR:  y_o = ~(a_i ^ b_i);
         OP_NOTA:  y_o = ~a_i;
         OP_PASSB: y_o = b_i;
         default:  y_o = '0;
      endcase
   end

   assign zero_o = (y_o == '0);
   assign ones_o = &y_o;

endmodule

// File: rtl/logic_unit.sv
// -----------------------------------------------------------------------------
// logic_unit
// Registered bitwise logic unit with valid/ready handshakes and a two-entry
// output skid buffer (main + skid), sustaining one result per cycle.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake (in_ready depends on state only)
//   in_op, in_a, in_b     : operation select and WIDTH-bit operands
//   out_valid/out_ready   : output handshake
//   out_y                 : result from the main entry
//   out_zero, out_ones    : flags captured alongside the result
//   txn_count             : accepted inputs modulo 2^COUNT_W
// -----------------------------------------------------------------------------
module logic_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  op_t                in_op,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_y,
   output logic               out_zero,
   output logic               out_ones,
   output logic [COUNT_W-1:0] txn_count
);

   // Stored entry layout: {ones, zero, y}
   localparam int EW = WIDTH + 2;

   logic [WIDTH-1:0]   core_y;
   logic               core_zero;
   logic               core_ones;
   logic [EW-1:0]      core_word;

   logic               main_vld_q, main_vld_d;
   logic [EW-1:0]      main_q,     main_d;
   logic               skid_vld_q, skid_vld_d;
   logic [EW-1:0]      skid_q,     skid_d;
   logic [COUNT_W-1:0] cnt_q,      cnt_d;

   logic               accept;
   logic               pop;
   logic               main_load_core;
   logic               main_load_skid;
   logic               skid_load;

   logic_unit_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op_i   (in_op),
      .a_i    (in_a),
      .b_i    (in_b),
      .y_o    (core_y),
      .zero_o (core_zero),
      .ones_o (core_ones)
   );

   assign core_word = {core_ones, core_zero, core_y};

   // Registered-only ready: the skid slot is the only thing that can refuse.
   assign in_ready = !skid_vld_q;
   assign accept   = in_valid && in_ready;
   assign pop      = main_vld_q && out_ready;

   always_comb begin
      main_vld_d     = main_vld_q;
      skid_vld_d     = skid_vld_q;
      main_load_core = 1'b0;
      main_load_skid = 1'b0;
      skid_load      = 1'b0;
      if (!main_vld_q || pop) begin
         // Main is free this edge; an older skid result has priority over a
         // new input (and in_ready is low whenever skid is full anyway).
         if (skid_vld_q) begin
            main_load_skid = 1'b1;
            main_vld_d     = 1'b1;
            skid_vld_d     = 1'b0;
         end else if (accept) begin
            main_load_core = 1'b1;
            main_vld_d     = 1'b1;
         end else begin
            main_vld_d     = 1'b0;
         end
      end else if (accept) begin
         // Main stalled: park the new result in skid.
         skid_load  = 1'b1;
         skid_vld_d = 1'b1;
      end
   end

   always_comb begin
      main_d = main_q;
      if (main_load_skid) begin
         main_d = skid_q;
      end else if (main_load_core) begin
         main_d = core_word;
      end
   end

   assign skid_d = skid_load ? core_word : skid_q;
   assign cnt_d  = accept ? cnt_q + COUNT_W'(1) : cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld_q <= 1'b0;
         main_q     <= '0;
         skid_vld_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         main_q     <= main_d;
         skid_vld_q <= skid_vld_d;
         cnt_q      <= cnt_d;
      end
   end

   // Skid payload is only meaningful while skid_vld_q is set, so it needs no reset.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

   assign out_valid = main_vld_q;
   assign out_y     = main_q[WIDTH-1:0];
   assign out_zero  = main_q[WIDTH];
   assign out_ones  = main_q[WIDTH+1];
   assign txn_count = cnt_q;

endmodule

// File: tb/tb_logic_unit.sv
module tb_logic_unit;
   import cpu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   // WIDTH=8, COUNT_W=16 instance
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  in_op;
   logic [7:0]  in_a, in_b, out_y;
   logic        out_zero, out_ones;
   logic [15:0] txn_count;

   // WIDTH=1, COUNT_W=4 instance
   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [2:0]  s_op;
   logic [0:0]  s_a, s_b, s_y;
   logic        s_zero, s_ones;
   logic [3:0]  s_cnt;

   logic_unit #(.WIDTH(8), .COUNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .out_zero(out_zero), .out_ones(out_ones), .txn_count(txn_count)
   );

   logic_unit #(.WIDTH(1), .COUNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_op), .in_a(s_a), .in_b(s_b),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_y(s_y),
      .out_zero(s_zero), .out_ones(s_ones), .txn_count(s_cnt)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: truth table of each operation for a single bit position.
   function automatic logic ref_bit(input logic [2:0] op, input logic a, input logic b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return !(a | b);
         3'd3:    return !(a & b);
         3'd4:    return a != b;
         3'd5:    return a == b;
         3'd6:    return !a;
         default: return b;
      endcase
   endfunction

   // Returns {ones, zero, y} for an 8-bit operand pair.
   function automatic logic [9:0] ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] y;
      for (int i = 0; i < 8; i++) y[i] = ref_bit(op, a[i], b[i]);
      return {(y == 8'hFF), (y == 8'h00), y};
   endfunction

   logic [9:0]  sb_q[$];
   int unsigned exp_cnt = 0;

   // Scoreboard feed: record each accepted input just after the handshake is settled.
   always @(negedge clk) begin
      #1;
      if (rst_n && in_valid && in_ready) begin
         sb_q.push_back(ref8(in_op, in_a, in_b));
         exp_cnt = (exp_cnt + 1) & 32'hFFFF;
      end
   end

   // Monitor: occupancy predicts the handshake signals; pops are compared in order.
   always @(negedge clk) begin
      logic [9:0] e;
      if (rst_n) begin
         chk("in_ready", in_ready, sb_q.size() < 2);
         chk("out_valid", out_valid, sb_q.size() > 0);
         chk("txn_count", txn_count, exp_cnt);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_empty: got out_y %0h expected no output", out_y);
            end else begin
               e = sb_q.pop_front();
               chk("out_y", out_y, e[7:0]);
               chk("out_zero", out_zero, e[8]);
               chk("out_ones", out_ones, e[9]);
            end
         end
      end
   end

   // Present one input and hold it until accepted; called at posedge+1.
   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      logic [7:0] tbl [8];
      int         cnt1;
      logic       r;
      tbl[0] = 8'hC0; tbl[1] = 8'hFC; tbl[2] = 8'h03; tbl[3] = 8'h3F;
      tbl[4] = 8'h3C; tbl[5] = 8'hC3; tbl[6] = 8'h0F; tbl[7] = 8'hCC;

      rst_n = 1'b0;
      in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_op = '0; s_a = '0; s_b = '0; s_out_ready = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_txn_count", txn_count, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_flags", {out_zero, out_ones}, 0);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Truth sweep, back-to-back, latency 1
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_op = 3'(i); in_a = 8'hF0; in_b = 8'hCC;
         if (i > 0) begin
            chk("sweep_y", out_y, tbl[i-1]);
            chk("sweep_valid", out_valid, 1);
            chk("sweep_in_ready", in_ready, 1);
         end
         @(posedge clk); #1;
      end
      chk("sweep_y_last", out_y, tbl[7]);

      // Flag corners
      in_op = OP_NOR; in_a = 8'h00; in_b = 8'h00;
      @(posedge clk); #1;
      chk("nor_y", out_y, 8'hFF);
      chk("nor_ones", out_ones, 1);
      in_op = OP_AND; in_a = 8'h0F; in_b = 8'hF0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("and_y", out_y, 8'h00);
      chk("and_zero", out_zero, 1);
      chk("and_ones", out_ones, 0);
      @(posedge clk); #1;

      // Backpressure: two accepted, third waits for the skid to drain
      out_ready = 1'b0;
      send(OP_XOR, 8'h12, 8'h34);
      send(OP_OR, 8'hA5, 8'h0F);
      in_valid = 1'b1; in_op = OP_NAND; in_a = 8'h5A; in_b = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready_low", in_ready, 0);
         chk("bp_hold_y", out_y, ref8(OP_XOR, 8'h12, 8'h34) & 10'h0FF);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_still_low", in_ready, 0);
      @(posedge clk); #1;
      chk("bp_in_ready_rise", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_third_y", out_y, ref8(OP_NAND, 8'h5A, 8'hFF) & 10'h0FF);
      @(posedge clk); #1;

      // Reset mid-stream with both entries full
      out_ready = 1'b0;
      send(OP_XNOR, 8'h3C, 8'h55);
      send(OP_NOTA, 8'h81, 8'h00);
      chk("pre_rst_in_ready", in_ready, 0);
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      exp_cnt = 0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_txn_count", txn_count, 0);
      chk("mid_rst_out_y", out_y, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Randomized traffic with random backpressure
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_op     = 3'($urandom_range(0, 7));
         in_a      = 8'($urandom);
         in_b      = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      chk("drain_empty", sb_q.size(), 0);

      // WIDTH=1 instance: all ops over the four input combinations; counter wraps at 16
      cnt1 = 0;
      for (int op = 0; op < 8; op++) begin
         for (int ab = 0; ab < 4; ab++) begin
            s_in_valid = 1'b1; s_op = 3'(op);
            s_a = 1'(ab >> 1); s_b = 1'(ab & 1);
            r = ref_bit(3'(op), s_a[0], s_b[0]);
            @(posedge clk); #1;
            cnt1 = (cnt1 + 1) % 16;
            chk("w1_y", s_y, r);
            chk("w1_zero", s_zero, !r);
            chk("w1_ones", s_ones, r);
            chk("w1_valid", s_out_valid, 1);
            chk("w1_in_ready", s_in_ready, 1);
            chk("w1_txn_count", s_cnt, cnt1);
         end
      end
      s_in_valid = 1'b0;
      @(posedge clk); #1;
      chk("w1_idle_valid", s_out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
